// File: rtl/pulse_period_meter.sv
// Measures the number of enabled clock cycles between two consecutive rising edges of evt.
// Optional timeout on long measurements is compiled in with `define PULSE_METER_TIMEOUT_EN.
module pulse_period_meter #(
  parameter int Bits    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic            start,
  input  logic            evt,
  input  logic            rdy,
  output logic [Bits-1:0] period,
  output logic            vld,
  output logic            ovf,
  output logic            tmo,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_COUNT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [Bits-1:0] CNT_MAX = '1;
  localparam logic [Bits-1:0] CNT_ONE = Bits'(1);

  // Out-of-range TIMEOUT values elaborate this empty block, making them visible in the hierarchy.
  if (TIMEOUT < 1 || TIMEOUT > (2 ** Bits) - 1) begin : g_timeout_out_of_range
  end

  state_t          state_q, state_d;
  logic [Bits-1:0] cnt_q, cnt_d;
  logic            evt_q, evt_d;
  logic [Bits-1:0] period_q, period_d;
  logic            vld_q, vld_d;
  logic            ovf_q, ovf_d;
  logic            rise;

`ifdef PULSE_METER_TIMEOUT_EN
  localparam logic [Bits-1:0] TIMEOUT_VAL = Bits'(TIMEOUT);
  logic            tmo_q, tmo_d;
`endif

  assign rise = evt & ~evt_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    evt_d    = evt_q;
    period_d = period_q;
    vld_d    = vld_q;
    ovf_d    = ovf_q;
`ifdef PULSE_METER_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    if (clr) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      evt_d    = 1'b0;
      period_d = '0;
      vld_d    = 1'b0;
      ovf_d    = 1'b0;
`ifdef PULSE_METER_TIMEOUT_EN
      tmo_d    = 1'b0;
`endif
    end else if (en) begin
      evt_d = evt;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_ARM;
            ovf_d   = 1'b0;
`ifdef PULSE_METER_TIMEOUT_EN
            tmo_d   = 1'b0;
`endif
          end
        end
        S_ARM: begin
          if (rise) begin
            state_d = S_COUNT;
            cnt_d   = CNT_ONE;
          end
        end
        S_COUNT: begin
          if (rise) begin
            state_d  = S_HOLD;
            period_d = cnt_q;
            vld_d    = 1'b1;
`ifdef PULSE_METER_TIMEOUT_EN
          end else if (cnt_q == TIMEOUT_VAL) begin
            state_d  = S_HOLD;
            period_d = TIMEOUT_VAL;
            tmo_d    = 1'b1;
            vld_d    = 1'b1;
`endif
          end else if (cnt_q == CNT_MAX) begin
            // Counter sticks at all-ones; ovf marks the result as clipped.
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_HOLD: begin
          if (rdy) begin
            vld_d = 1'b0;
            if (start) begin
              state_d = S_ARM;
              ovf_d   = 1'b0;
`ifdef PULSE_METER_TIMEOUT_EN
              tmo_d   = 1'b0;
`endif
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      evt_q    <= 1'b0;
      period_q <= '0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      evt_q    <= evt_d;
      period_q <= period_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef PULSE_METER_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
  assign tmo = tmo_q;
`else
  assign tmo = 1'b0;
`endif

  assign period = period_q;
  assign vld    = vld_q;
  assign ovf    = ovf_q;
  assign busy   = (state_q == S_ARM) || (state_q == S_COUNT);

endmodule

// File: tb/tb_pulse_period_meter.sv
// Randomized bench for pulse_period_meter: a timestamp-based reference model predicts every output each cycle.
module tb_pulse_period_meter;

  localparam int BITS = 4;
  localparam int TO   = 10;
  localparam int MAXC = (2 ** BITS) - 1;

  logic            clk = 1'b0;
  logic            rst, clr, en, start, evt, rdy;
  logic [BITS-1:0] period;
  logic            vld, ovf, tmo, busy;

  int checks = 0;
  int errors = 0;

  pulse_period_meter #(.Bits(BITS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .start(start), .evt(evt), .rdy(rdy),
    .period(period), .vld(vld), .ovf(ovf), .tmo(tmo), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: what the block is doing, plus the enabled-cycle timestamp of the first rise.
  typedef enum int {M_IDLE, M_WAIT_FIRST, M_MEASURE, M_RESULT} mphase_t;
  mphase_t m_ph;
  int      m_t, m_t0, m_period;
  bit      m_prev, m_vld, m_ovf, m_tmo;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = M_IDLE; m_t = 0; m_t0 = 0; m_period = 0;
    m_prev = 1'b0; m_vld = 1'b0; m_ovf = 1'b0; m_tmo = 1'b0;
  endtask

  task automatic model_step();
    bit rise;
    int d;
    if (clr) begin
      model_reset();
    end else if (en) begin
      rise   = evt && !m_prev;
      m_prev = evt;
      m_t++;
      case (m_ph)
        M_IDLE: if (start) begin m_ph = M_WAIT_FIRST; m_ovf = 0; m_tmo = 0; end
        M_WAIT_FIRST: if (rise) begin m_t0 = m_t; m_ph = M_MEASURE; end
        M_MEASURE: begin
          d = m_t - m_t0;
          if (rise) begin
            m_period = (d > MAXC) ? MAXC : d;
            m_ovf = (d > MAXC); m_vld = 1; m_ph = M_RESULT;
`ifdef PULSE_METER_TIMEOUT_EN
          end else if (d == TO) begin
            m_period = TO; m_tmo = 1; m_vld = 1; m_ph = M_RESULT;
`endif
          end else if (d >= MAXC) begin
            m_ovf = 1;
          end
        end
        M_RESULT: if (rdy) begin
          m_vld = 0;
          if (start) begin m_ph = M_WAIT_FIRST; m_ovf = 0; m_tmo = 0; end
          else m_ph = M_IDLE;
        end
        default: m_ph = M_IDLE;
      endcase
    end
  endtask

  task automatic compare_all();
    check_eq("vld", 32'(vld), 32'(m_vld));
    check_eq("period", 32'(period), 32'(m_period));
    check_eq("ovf", 32'(ovf), 32'(m_ovf));
    check_eq("tmo", 32'(tmo), 32'(m_tmo));
    check_eq("busy", 32'(busy), 32'((m_ph == M_WAIT_FIRST) || (m_ph == M_MEASURE)));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  int gap_left;

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b0; start = 1'b0; evt = 1'b0; rdy = 1'b0;
    model_reset();
    #2;
    compare_all();
    #1 rst = 1'b0;

    // Rises five enabled cycles apart, consumer ready.
    en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; evt = 1'b1;
    tick();
    evt = 1'b0;
    repeat (4) tick();
    evt = 1'b1;
    tick();
    check_eq("dir_period5", 32'(period), 32'd5);
    check_eq("dir_vld5", 32'(vld), 32'd1);
    evt = 1'b0; rdy = 1'b1;
    tick();
    check_eq("dir_vld_drop", 32'(vld), 32'd0);
    check_eq("dir_busy_idle", 32'(busy), 32'd0);
    rdy = 1'b0;

    // Long gap saturates the 4-bit counter.
    start = 1'b1;
    tick();
    start = 1'b0; evt = 1'b1;
    tick();
    evt = 1'b0;
    repeat (19) tick();
    evt = 1'b1;
    tick();
    check_eq("dir_sat_period", 32'(period), 32'(MAXC));
    check_eq("dir_sat_ovf", 32'(ovf), 32'd1);
    evt = 1'b0; rdy = 1'b1; start = 1'b1;
    tick();
    check_eq("dir_rearm_ovf", 32'(ovf), 32'd0);
    check_eq("dir_rearm_busy", 32'(busy), 32'd1);
    rdy = 1'b0; start = 1'b0;

    // Randomized traffic with enable gaps, clears and asynchronous resets.
    gap_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (gap_left == 0) begin
        evt = 1'b1;
        gap_left = $urandom_range(1, 22);
      end else begin
        evt = 1'b0;
        gap_left--;
      end
      start = ($urandom_range(0, 3) == 0);
      rdy   = ($urandom_range(0, 2) == 0);
      en    = ($urandom_range(0, 9) != 0);
      clr   = ($urandom_range(0, 199) == 0);
      tick();
      if ($urandom_range(0, 249) == 0) begin
        #3 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        #1 rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_period_meter.md
PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 Parameter Bits, default 8: width of the period result and of the internal cycle counter.
REQ-002 Parameter TIMEOUT, default 200: cycle limit for the timeout feature; valid range 1..2^Bits-1.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 clr  input  1  synchronous clear; returns the block to its reset state.
REQ-006 en  input  1  global enable; when low, FSM, counter and edge history hold.
REQ-007 start  input  1  arm request; sampled only in IDLE and HOLD.
REQ-008 evt  input  1  level input whose rising edges delimit the measured period.
REQ-009 rdy  input  1  consumer accepts the result when high with vld.
REQ-010 period  output  Bits  measured cycle count between two consecutive rising edges of evt.
REQ-011 vld  output  1  period, ovf and tmo are valid.
REQ-012 ovf  output  1  count saturated at 2^Bits-1.
REQ-013 tmo  output  1  measurement ended by timeout.
REQ-014 busy  output  1  high in ARM and COUNT.

Function
REQ-015 The block SHALL register evt each enabled cycle as evt_q; rise = evt & ~evt_q.
REQ-016 The FSM SHALL have four states: IDLE, ARM, COUNT and HOLD.
REQ-017 IDLE: start=1 -> ARM; otherwise stay in IDLE.
REQ-018 ARM: rise=1 -> COUNT with counter loaded to 1; otherwise stay in ARM.
REQ-019 COUNT: rise=1 -> HOLD with period = counter and vld=1; otherwise counter increments by 1.
REQ-020 Period definition: rises at enabled cycles t0 and t1 SHALL give period = t1 - t0 (consecutive rises at t0 and t0+2 give 2).
REQ-021 The counter SHALL saturate at 2^Bits-1 and set sticky ovf for the current measurement; it never wraps.
REQ-022 HOLD: period, ovf, tmo and vld SHALL hold stable until vld & rdy.
REQ-023 HOLD with vld & rdy: start=1 -> ARM, else -> IDLE; vld drops in the next cycle.
REQ-024 start in ARM or COUNT SHALL be ignored; rise in IDLE or HOLD SHALL be ignored.
REQ-025 On entry to ARM, ovf and tmo SHALL clear; period retains its last value.
REQ-026 en=0 SHALL freeze state, counter, evt_q and outputs; rdy is ignored while en=0.
REQ-027 clr=1 SHALL take priority over en and all other inputs, with the same effect as reset at the next edge.
REQ-028 busy SHALL be a combinational decode of state (ARM or COUNT); all other outputs SHALL be registered.

Reset
REQ-029 On rst: state=IDLE, counter=0, evt_q=0, period=0, vld=0, ovf=0, tmo=0, busy=0.
REQ-030 rst asserted mid-measurement SHALL abort without producing vld.
REQ-031 A high evt at the first enabled cycle after reset SHALL count as a rise (evt_q=0).

Configuration
REQ-032 Macro PULSE_METER_TIMEOUT_EN SHALL control the timeout feature.
REQ-033 With PULSE_METER_TIMEOUT_EN defined: in COUNT, with counter == TIMEOUT and no rise, go to HOLD with period=TIMEOUT, tmo=1, vld=1.
REQ-034 With PULSE_METER_TIMEOUT_EN defined, a rise in the same cycle as the timeout condition SHALL win: normal result, tmo=0.
REQ-035 Without PULSE_METER_TIMEOUT_EN: tmo SHALL be constant 0, no timeout logic SHALL exist, and COUNT waits indefinitely with saturation.
REQ-036 The TIMEOUT parameter SHALL be present but unused when the macro is undefined.

Verification
REQ-037 Bits=8: start, rises 5 cycles apart, rdy=1 -> period=5, vld one cycle, ovf=0, tmo=0, back to IDLE.
REQ-038 Bits=4, macro undefined: rises 20 cycles apart -> period=15, ovf=1; next start clears ovf.
REQ-039 Macro defined, TIMEOUT=10: single rise, no second -> period=10, tmo=1; with a rise at the exact timeout cycle -> period=10, tmo=0.
REQ-040 rdy held low 7 cycles in HOLD with further evt rises -> outputs stable; start+rdy together -> ARM directly, busy=1.
REQ-041 en=0 for 3 cycles mid-COUNT with rises 6 enabled cycles apart -> period=6; clr in COUNT -> IDLE, all outputs 0.
REQ-042 rst pulse mid-COUNT (asynchronous, between edges) -> outputs 0 immediately; no vld afterwards without a new start.
